// File: rtl/g_inverse_function_if.sv
// Stream bundle for the inverse G block: input word set with its valid/ready
// pair, and recovered word set with its valid/ready pair.
interface g_inverse_function_if;
    logic        Valid_I;
    logic        Ready_O;
    logic [31:0] A_I;
    logic [31:0] B_I;
    logic [31:0] C_I;
    logic [31:0] D_I;
    logic [31:0] X_I;
    logic [31:0] Y_I;
    logic        Valid_O;
    logic        Ready_I;
    logic [31:0] A_O;
    logic [31:0] B_O;
    logic [31:0] C_O;
    logic [31:0] D_O;

    // Upstream producer / downstream consumer side (testbench, FIFO glue)
    modport master (
        output Valid_I, A_I, B_I, C_I, D_I, X_I, Y_I, Ready_I,
        input  Ready_O, Valid_O, A_O, B_O, C_O, D_O
    );

    // Inverse G core side
    modport slave (
        input  Valid_I, A_I, B_I, C_I, D_I, X_I, Y_I, Ready_I,
        output Ready_O, Valid_O, A_O, B_O, C_O, D_O
    );
endinterface

// File: rtl/g_inverse_function.sv
// Four-stage pipelined inverse of the BLAKE-style G mix (rotations 16/12/8/7).
// Recovers (a,b,c,d) from G's outputs and the same X/Y message words.
// A single global advance signal stalls every stage together; bubbles are kept.
module g_inverse_function (
    input  logic                  Clk,
    input  logic                  Rst,
    g_inverse_function_if.slave   io
);

    logic adv;

    logic        v1, v2, v3, v4;
    logic [31:0] a1, b1, c1, d1, x1, y1;
    logic [31:0] a2, b2, c2, d2, x2;
    logic [31:0] a3, b3, c3, d3, x3;
    logic [31:0] a4, b4, c4, d4;

    // Whole pipe moves when the output slot is empty or being drained
    always_comb begin
        adv        = io.Ready_I | ~v4;
        io.Ready_O = adv;
    end

    // S1: undo the last b rotation/xor and the last c add
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            c1 <= '0;
            d1 <= '0;
            x1 <= '0;
            y1 <= '0;
        end else if (adv) begin
            v1 <= io.Valid_I;
            a1 <= io.A_I;
            b1 <= {io.B_I[24:0], io.B_I[31:25]} ^ io.C_I;
            c1 <= io.C_I - io.D_I;
            d1 <= io.D_I;
            x1 <= io.X_I;
            y1 <= io.Y_I;
        end
    end

    // S2: undo the d rotation by 8 and the second a add (uses Y)
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v2 <= 1'b0;
            a2 <= '0;
            b2 <= '0;
            c2 <= '0;
            d2 <= '0;
            x2 <= '0;
        end else if (adv) begin
            v2 <= v1;
            a2 <= a1 - b1 - y1;
            b2 <= b1;
            c2 <= c1;
            d2 <= {d1[23:0], d1[31:24]} ^ a1;
            x2 <= x1;
        end
    end

    // S3: undo the b rotation by 12 and the first c add
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v3 <= 1'b0;
            a3 <= '0;
            b3 <= '0;
            c3 <= '0;
            d3 <= '0;
            x3 <= '0;
        end else if (adv) begin
            v3 <= v2;
            a3 <= a2;
            b3 <= {b2[19:0], b2[31:20]} ^ c2;
            c3 <= c2 - d2;
            d3 <= d2;
            x3 <= x2;
        end
    end

    // S4: undo the d rotation by 16 and the first a add (uses X); drives outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v4 <= 1'b0;
            a4 <= '0;
            b4 <= '0;
            c4 <= '0;
            d4 <= '0;
        end else if (adv) begin
            v4 <= v3;
            a4 <= a3 - b3 - x3;
            b4 <= b3;
            c4 <= c3;
            d4 <= {d3[15:0], d3[31:16]} ^ a3;
        end
    end

    // Output registers are exposed directly
    always_comb begin
        io.Valid_O = v4;
        io.A_O     = a4;
        io.B_O     = b4;
        io.C_O     = c4;
        io.D_O     = d4;
    end

endmodule
